channel_fifo: RTL and testbench
===============================

# channel_fifo

Synchronous FIFO channel that sits between HLS-generated kernels. It is the responder end of the kernel channel protocol: kernels drive `write_valid`/`in_data` to push and `read_valid` to pop, and this block answers with `write_ready`, `read_ready` and `out_data`. A reduce kernel's input port and a producer kernel's output port both attach here, so one instance links a producer to a consumer.

## Interface
- `WIDTH`, 32, data word width in bits.
- `DEPTH`, 16, number of storage entries. Must be a power of two, ≥ 2.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_data` input WIDTH: word to push. Sampled when `write_valid && write_ready`.
- `write_valid` input 1: push request, one word per asserted cycle.
- `read_valid` input 1: pop request, one word per asserted cycle.
- `out_data` output WIDTH: registered copy of the most recently popped word.
- `read_ready` output 1: FIFO is non-empty, so a pop will be accepted.
- `write_ready` output 1: FIFO is not full, so a push will be accepted.

## Operation
- State:
  - `mem[DEPTH]` of WIDTH bits.
  - `wr_ptr` and `rd_ptr`, each clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
  - `count`, clog2(DEPTH)+1 bits, range 0..DEPTH.
  - `out_data` register.
- Status outputs are combinational from `count`:
  - `read_ready = (count != 0)`
  - `write_ready = (count != DEPTH)`
- Push, when `write_valid && write_ready`: `mem[wr_ptr] <= in_data` and `wr_ptr <= wr_ptr+1`.
- Pop, when `read_valid && read_ready`: `out_data <= mem[rd_ptr]` and `rd_ptr <= rd_ptr+1`.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Rejected requests:
  - A push while full is dropped silently. No state changes and the word is lost. The producer must wait for `write_ready`.
  - A pop while empty is ignored. `out_data` holds its previous value and `rd_ptr` is unchanged.
- Boundary cases:
  - Simultaneous push and pop while empty: the push is accepted and the pop is rejected. There is no write-to-read bypass, and `count` becomes 1.
  - Simultaneous push and pop while full: the pop is accepted and the push is rejected. `count` becomes DEPTH−1.
  - Simultaneous push and pop at 0 < count < DEPTH: both are accepted and `count` is unchanged. The pop reads the old `mem[rd_ptr]`; it never reads the word being written this cycle, because `rd_ptr != wr_ptr` whenever `count > 0`.
  - Pointer wrap-around is transparent. Ordering is strictly FIFO across the wrap.

## Timing
- Reset (`rst == 0` at a rising edge):
  - `wr_ptr`, `rd_ptr`, `count` and `out_data` are cleared to 0 on that edge.
  - Following the reset edge: `read_ready = 0`, `write_ready = 1`, `out_data = 0`.
  - `mem` contents are not cleared.
  - Reset overrides any simultaneous push or pop. A request asserted in the reset cycle is discarded.
- Pop latency: with `read_valid` high in cycle N, `out_data` shows the popped word from cycle N+1. It stays stable until the next accepted pop.
  - This matches kernels that pulse `read_valid` in one state and consume `out_data` in the next.
- Push-to-readable latency: a word pushed in cycle N raises `read_ready` in cycle N+1. It can be popped in N+1 and appears on `out_data` in N+2.
- Full-to-not-full: `write_ready` rises the cycle after a pop from a full FIFO.
- Throughput: one push and one pop per cycle, sustained.
- No combinational path from `in_data` or `write_valid` to any output. Outputs depend only on registers.

## Structure
- Add to the shared package: a `clog2` constant function, plus `CHANNEL_WIDTH_DEFAULT = 32` and `CHANNEL_DEPTH_DEFAULT = 16`, also used by kernel wrappers.
- Keep the storage array inline; no sub-module is required.
- Optionally factor the pointer/count logic into `channel_fifo_ctrl` (ptrs, count, ready flags) if a second channel variant (e.g. depth-1 register) is added later.

## Test plan
- Reset: hold `rst = 0` for 2 cycles with `write_valid = read_valid = 1`, then release → `read_ready = 0`, `write_ready = 1`, `out_data = 0`, and `count` stays 0.
- Ordered fill/drain, DEPTH = 16:
  - Push 1..16 in consecutive cycles → `write_ready = 0` after the 16th push.
  - A 17th push of 99 is dropped.
  - Pop 16 times → `out_data` reads 1..16, one cycle after each pop. `read_ready = 0` after the last pop.
  - A further pop leaves `out_data = 16`.
- Reduce-kernel pattern: push 3, 5, 7, 9, then pop with one-cycle `read_valid` pulses separated by idle cycles → `out_data` reads 3, 5, 7, 9 in turn, each held stable through the idle cycles. The sum of the four reads is 24.
- Simultaneous push/pop:
  - Empty with `in_data = 42` → `count = 1`, `out_data` unchanged.
  - Full → one pop accepted, push dropped, `count = 15`.
  - With count = 5 → `count` stays 5 and order is preserved.
- Wrap-around: 40 cycles of random push/pop with a scoreboard. Pointers wrap at least twice and every popped value matches the model.
- Mid-operation reset: with count = 7, assert `rst = 0` for one cycle → `count = 0`, `read_ready = 0`. A subsequent push of 11 then a pop returns 11.

Source files
------------

// File: rtl/channel_fifo_pkg.sv
// Shared channel definitions used by channel_fifo and the kernel wrappers.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package channel_fifo_pkg;

    localparam int CHANNEL_WIDTH_DEFAULT = 32;
    localparam int CHANNEL_DEPTH_DEFAULT = 16;

    // Ceiling log2, evaluated at elaboration time to size pointers and counters.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/channel_fifo_ctrl.sv
// Pointer/occupancy control for a power-of-two channel FIFO.
// Latency: flags are registered-state decodes; a push shows on read_ready the next cycle.
// Backpressure: write_ready drops at DEPTH entries, read_ready drops at zero; rejected requests are ignored.
//
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   write_valid         - push request from the producer
//   read_valid          - pop request from the consumer
//   push, pop           - accepted-transfer strobes for the storage datapath
//   wr_ptr, rd_ptr      - storage addresses for this cycle's push/pop
//   read_ready          - FIFO holds at least one word
//   write_ready         - FIFO has at least one free entry
module channel_fifo_ctrl
    import channel_fifo_pkg::*;
#(
    parameter int DEPTH = CHANNEL_DEPTH_DEFAULT,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_valid,
    input  logic          read_valid,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic          read_ready,
    output logic          write_ready
);

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

    logic [AW:0] count;
    logic [AW:0] count_next;

    // Flags decode only the registered count, so no input reaches an output
    // combinationally.
    assign read_ready  = (count != '0);
    assign write_ready = (count != COUNT_FULL);

    // A push while full or a pop while empty is simply not accepted. With
    // both requests at the empty/full boundaries, only the one the current
    // occupancy allows goes through; there is no write-to-read bypass.
    assign push = write_valid && write_ready;
    assign pop  = read_valid && read_ready;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/channel_fifo.sv
// Synchronous FIFO channel linking a producer kernel's output to a consumer kernel's input.
// Latency: popped word appears on out_data the cycle after read_valid; pushed word is poppable the next cycle.
// Backpressure: write_ready low when full (pushes dropped), read_ready low when empty (pops ignored).
//
// Ports:
//   clk, rst     - clock, synchronous active-low reset
//   in_data      - word to push, taken when write_valid && write_ready
//   write_valid  - push request, one word per asserted cycle
//   read_valid   - pop request, one word per asserted cycle
//   out_data     - registered copy of the most recently popped word
//   read_ready   - FIFO non-empty
//   write_ready  - FIFO not full
module channel_fifo
    import channel_fifo_pkg::*;
#(
    parameter int WIDTH = CHANNEL_WIDTH_DEFAULT,
    parameter int DEPTH = CHANNEL_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             write_valid,
    input  logic             read_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             read_ready,
    output logic             write_ready
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             push;
    logic             pop;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    channel_fifo_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .write_valid (write_valid),
        .read_valid  (read_valid),
        .push        (push),
        .pop         (pop),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .read_ready  (read_ready),
        .write_ready (write_ready)
    );

    // Storage is not reset; gating the write with rst keeps a request that
    // coincides with reset from touching the array at all.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // When pushing and popping together at 0 < count < DEPTH the pointers
    // differ, so this read always sees the previously stored word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data <= '0;
        end else if (pop) begin
            out_data <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_channel_fifo.sv
// Self-checking bench for channel_fifo against a queue-based reference model.
// Latency: checks are taken 1 ns after each rising edge.
// Backpressure: model drops pushes at DEPTH entries and ignores pops when empty.
module tb_channel_fifo;
    import channel_fifo_pkg::*;

    localparam int WIDTH = CHANNEL_WIDTH_DEFAULT;
    localparam int DEPTH = CHANNEL_DEPTH_DEFAULT;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             write_valid;
    logic             read_valid;
    logic [WIDTH-1:0] out_data;
    logic             read_ready;
    logic             write_ready;

    int tests;
    int fails;

    // Reference model state
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_out;
    int               model_pushes;

    channel_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .write_valid (write_valid),
        .read_valid  (read_valid),
        .out_data    (out_data),
        .read_ready  (read_ready),
        .write_ready (write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive requests, advance the model on the edge, then
    // compare all outputs with the model.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
        bit do_push;
        bit do_pop;
        write_valid = w;
        read_valid  = r;
        in_data     = d;
        @(posedge clk);
        if (!rst) begin
            model_q.delete();
            model_out = '0;
        end else begin
            do_push = w && (model_q.size() < DEPTH);
            do_pop  = r && (model_q.size() > 0);
            if (do_pop) model_out = model_q.pop_front();
            if (do_push) begin
                model_q.push_back(d);
                model_pushes++;
            end
        end
        #1;
        check({tag, ".out_data"}, out_data, model_out);
        check({tag, ".read_ready"}, {{(WIDTH-1){1'b0}}, read_ready}, WIDTH'(model_q.size() != 0));
        check({tag, ".write_ready"}, {{(WIDTH-1){1'b0}}, write_ready}, WIDTH'(model_q.size() != DEPTH));
    endtask

    initial begin
        int sum;
        int phase_start;
        int cyc;
        tests        = 0;
        fails        = 0;
        model_out    = '0;
        model_pushes = 0;
        rst          = 1'b0;
        write_valid  = 1'b0;
        read_valid   = 1'b0;
        in_data      = '0;

        // Reset held two cycles with both requests asserted.
        step(1'b1, 1'b1, 32'd77, "reset0");
        step(1'b1, 1'b1, 32'd78, "reset1");
        rst = 1'b1;
        check("reset.read_ready", {31'd0, read_ready}, 32'd0);
        check("reset.write_ready", {31'd0, write_ready}, 32'd1);
        check("reset.out_data", out_data, 32'd0);
        step(1'b0, 1'b0, '0, "reset_idle");
        check("reset.still_empty", {31'd0, read_ready}, 32'd0);

        // Ordered fill and drain.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i), "fill");
        check("fill.write_ready_low", {31'd0, write_ready}, 32'd0);
        step(1'b1, 1'b0, 32'd99, "fill_overflow");
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            check("drain.order", out_data, WIDTH'(i));
        end
        check("drain.read_ready_low", {31'd0, read_ready}, 32'd0);
        step(1'b0, 1'b1, '0, "underflow");
        check("underflow.hold", out_data, 32'd16);

        // Reduce-kernel pattern: pulsed pops separated by idle cycles.
        step(1'b1, 1'b0, 32'd3, "reduce_push");
        step(1'b1, 1'b0, 32'd5, "reduce_push");
        step(1'b1, 1'b0, 32'd7, "reduce_push");
        step(1'b1, 1'b0, 32'd9, "reduce_push");
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, '0, "reduce_pop");
            check("reduce.value", out_data, WIDTH'(3 + 2 * i));
            sum += int'(out_data);
            step(1'b0, 1'b0, '0, "reduce_idle");
            step(1'b0, 1'b0, '0, "reduce_idle");
            check("reduce.stable", out_data, WIDTH'(3 + 2 * i));
        end
        check("reduce.sum", WIDTH'(sum), 32'd24);

        // Simultaneous push/pop while empty: push wins, no bypass.
        step(1'b1, 1'b1, 32'd42, "both_empty");
        check("both_empty.out_hold", out_data, 32'd9);
        check("both_empty.read_ready", {31'd0, read_ready}, 32'd1);
        step(1'b0, 1'b1, '0, "both_empty_pop");
        check("both_empty.pop42", out_data, 32'd42);
        check("both_empty.count1", {31'd0, read_ready}, 32'd0);

        // Simultaneous push/pop while full: pop wins, count becomes DEPTH-1.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(100 + i), "full_fill");
        step(1'b1, 1'b1, 32'd500, "both_full");
        check("both_full.pop", out_data, 32'd100);
        check("both_full.write_ready", {31'd0, write_ready}, 32'd1);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, '0, "full_drain");
        check("both_full.last", out_data, 32'd115);
        check("both_full.count15", {31'd0, read_ready}, 32'd0);

        // Simultaneous push/pop at count 5: count held, order preserved.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(200 + i), "mid_fill");
        step(1'b1, 1'b1, 32'd205, "both_mid");
        check("both_mid.pop", out_data, 32'd200);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, '0, "mid_drain");
            check("both_mid.order", out_data, WIDTH'(200 + i));
        end
        check("both_mid.count5", {31'd0, read_ready}, 32'd0);

        // Random traffic across several pointer wraps.
        phase_start = model_pushes;
        cyc = 0;
        while (cyc < 40 || ((model_pushes - phase_start) < 2 * DEPTH && cyc < 400)) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), WIDTH'($urandom), "random");
            cyc++;
        end
        check("random.wraps", WIDTH'((model_pushes - phase_start) >= 2 * DEPTH), 32'd1);
        while (model_q.size() != 0) step(1'b0, 1'b1, '0, "random_drain");

        // Mid-operation reset with 7 words stored.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, WIDTH'(300 + i), "pre_reset");
        rst = 1'b0;
        step(1'b1, 1'b1, 32'd55, "mid_reset");
        rst = 1'b1;
        check("mid_reset.read_ready", {31'd0, read_ready}, 32'd0);
        check("mid_reset.out_data", out_data, 32'd0);
        step(1'b1, 1'b0, 32'd11, "post_reset_push");
        step(1'b0, 1'b1, '0, "post_reset_pop");
        check("mid_reset.pop11", out_data, 32'd11);
        check("mid_reset.empty", {31'd0, read_ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
